paint_pixel_responder: RTL

// - Fabric-side responder for the Nios paint-command PIO interface (currx/curry/color_from/command).
// - Latches one pixel command per 4-phase handshake and performs a single 16-bit SRAM frame-buffer access:

---
 rtl/paint_pkg.sv | 36 +++
 rtl/pixel_addr_gen.sv | 37 +++
 rtl/paint_pixel_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/paint_pkg.sv
// Shared types and defaults for the paint pixel responder.
// Op encodings, FSM states and the latched command bundle.
package paint_pkg;

   localparam int H_RES_DEF     = 640;
   localparam int V_RES_DEF     = 480;
   localparam int WE_CYCLES_DEF = 2;
   localparam int RD_CYCLES_DEF = 2;

   localparam int CW = 10;
   localparam int DW = 16;
   localparam int AW = 20;

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_READ  = 1'b1
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ADDR,
      S_WE,
      S_HOLD,
      S_RD,
      S_ACK
   } state_e;

   typedef struct packed {
      op_e           op;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [DW-1:0] color;
   } cmd_t;

endpackage

// File: rtl/pixel_addr_gen.sv
// Registered frame-buffer word address: y*H_RES + x.
// The 640-wide case uses two shifts instead of a multiplier.
module pixel_addr_gen
   import paint_pkg::*;
#(
   parameter int H_RES = H_RES_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [CW-1:0] x,
   input  logic [CW-1:0] y,
   output logic [AW-1:0] addr
);

   logic [AW-1:0] sum;

   generate
      if (H_RES == 640) begin : g_shift
         // 640 = 512 + 128
         always_comb begin
            sum = ({10'd0, y} << 9) + ({10'd0, y} << 7) + {10'd0, x};
         end
      end else begin : g_mul
         // generic width-exact product
         always_comb begin
            sum = 20'(32'(y) * 32'(H_RES) + 32'(x));
         end
      end
   endgenerate

   // register the address so it is stable by the ADDR state
   always_ff @(posedge clk) begin
      if (!reset_n) addr <= '0;
      else          addr <= sum;
   end

endmodule

// File: rtl/paint_pixel_responder.sv
// Nios paint-command responder: one SRAM pixel access per
// 4-phase req/ack handshake, shared SRAM with VGA scan-out.
module paint_pixel_responder
   import paint_pkg::*;
#(
   parameter int H_RES     = H_RES_DEF,
   parameter int V_RES     = V_RES_DEF,
   parameter int WE_CYCLES = WE_CYCLES_DEF,
   parameter int RD_CYCLES = RD_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cmd_req,
   input  logic          cmd_op,
   input  logic [CW-1:0] cmd_x,
   input  logic [CW-1:0] cmd_y,
   input  logic [DW-1:0] cmd_color,
   output logic          cmd_ack,
   output logic          cmd_err,
   output logic [DW-1:0] rd_color,
   input  logic          mem_busy,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_dq_out,
   output logic          sram_dq_oe,
   input  logic [DW-1:0] sram_dq_in,
   output logic          sram_ce_n,
   output logic          sram_oe_n,
   output logic          sram_we_n,
   output logic          sram_ub_n,
   output logic          sram_lb_n
);

   localparam logic [7:0] WE_LAST = 8'(WE_CYCLES - 1);
   localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);

   state_e     state;
   state_e     state_nx;
   cmd_t       cmd_q;
   logic [7:0] cnt;
   logic       out_of_range;
   logic       is_wr;

   assign is_wr        = (cmd_q.op == OP_WRITE);
   assign out_of_range = ({22'd0, cmd_q.x} >= 32'(H_RES))
                      || ({22'd0, cmd_q.y} >= 32'(V_RES));
   assign sram_dq_out  = cmd_q.color;

   pixel_addr_gen #(
      .H_RES (H_RES)
   ) u_addr (
      .clk     (clk),
      .reset_n (reset_n),
      .x       (cmd_q.x),
      .y       (cmd_q.y),
      .addr    (sram_addr)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // command latch, shared strobe counter, error and read result
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cmd_q    <= '0;
         cnt      <= '0;
         cmd_err  <= 1'b0;
         rd_color <= '0;
      end else begin
         if (state == S_IDLE && cmd_req) begin
            cmd_q   <= {op_e'(cmd_op), cmd_x, cmd_y, cmd_color};
            cmd_err <= 1'b0;
         end
         if (state == S_WAIT && out_of_range)
            cmd_err <= 1'b1;
         if (state == S_ADDR)
            cnt <= '0;
         else if (state == S_WE || state == S_RD)
            cnt <= cnt + 8'd1;
         if (state == S_RD && cnt == RD_LAST)
            rd_color <= sram_dq_in;
      end
   end

   // next state and SRAM strobes decoded from the current state
   always_comb begin
      state_nx   = state;
      cmd_ack    = 1'b0;
      sram_ce_n  = 1'b1;
      sram_oe_n  = 1'b1;
      sram_we_n  = 1'b1;
      sram_ub_n  = 1'b1;
      sram_lb_n  = 1'b1;
      sram_dq_oe = 1'b0;
      unique case (1'b1)
         (state == S_IDLE): begin
            if (cmd_req) state_nx = S_WAIT;
         end
         (state == S_WAIT): begin
            if (out_of_range)   state_nx = S_ACK;
            else if (!mem_busy) state_nx = S_ADDR;
         end
         (state == S_ADDR): begin
            sram_ce_n  = 1'b0;
            sram_ub_n  = 1'b0;
            sram_lb_n  = 1'b0;
            sram_dq_oe = is_wr;
            state_nx   = is_wr ? S_WE : S_RD;
         end
         (state == S_WE): begin
            sram_ce_n  = 1'b0;
            sram_ub_n  = 1'b0;
            sram_lb_n  = 1'b0;
            sram_we_n  = 1'b0;
            sram_dq_oe = 1'b1;
            if (cnt == WE_LAST) state_nx = S_HOLD;
         end
         (state == S_HOLD): begin
            sram_ce_n  = 1'b0;
            sram_ub_n  = 1'b0;
            sram_lb_n  = 1'b0;
            sram_dq_oe = 1'b1;
            state_nx   = S_ACK;
         end
         (state == S_RD): begin
            sram_ce_n = 1'b0;
            sram_ub_n = 1'b0;
            sram_lb_n = 1'b0;
            sram_oe_n = 1'b0;
            if (cnt == RD_LAST) state_nx = S_ACK;
         end
         (state == S_ACK): begin
            cmd_ack = 1'b1;
            if (!cmd_req) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule
